// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard and stall sequencer for the 5-stage MIPS pipeline.
// Produces every stage-register write-enable and flush from four stall sources:
// data-memory freeze, mult/div wait, post-jump/branch fetch suppression and
// load-use. Decisions are Mealy (same cycle as the inputs). A 32-bit counter
// accumulates the cycles in which the PC was not written.
module pipeline_stall_ctrl #(
  // fetch-suppression cycles after a jump/branch leaves ID; legal 0..7
  parameter int unsigned JB_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ID_Is_JB,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_Uses_Rt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        EX_MD_Start,
  input  logic        md_done,
  input  logic        mem_waitrequest,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        MEM_WB_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        Is_JB_stall,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    JB_WAIT = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  // One bundle for all stage controls so each stall flavour is a single constant.
  typedef struct packed {
    logic pc_w;
    logic if_id_w;
    logic id_ex_w;
    logic ex_mem_w;
    logic mem_wb_w;
    logic if_id_fl;
    logic id_ex_fl;
    logic ex_mem_fl;
  } ctrl_t;

  //                                    PC IF ID EX WB | fIF fID fEX
  localparam ctrl_t CTL_RUN    = 8'b1111_1000;
  localparam ctrl_t CTL_FREEZE = 8'b0000_0000;  // whole pipe holds, nothing flushed
  localparam ctrl_t CTL_MD     = 8'b0001_1001;  // front end holds, bubble into EX/MEM
  localparam ctrl_t CTL_JB     = 8'b0111_1100;  // PC holds, fetched slot squashed
  localparam ctrl_t CTL_LU     = 8'b0011_1010;  // PC + IF/ID hold, bubble into ID/EX

  localparam logic [2:0] JB_LOAD = 3'(JB_STALL_CYCLES);
  localparam logic       JB_EN   = (JB_STALL_CYCLES != 0);

  state_t      state, state_nxt;
  logic [2:0]  jb_cnt, jb_cnt_nxt;
  logic [31:0] stall_q;
  ctrl_t       ctl;
  logic        freeze, load_use, md_hold;

  // Hazard detection on the raw ID/EX fields.
  always_comb begin
    freeze   = mem_waitrequest;
    load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
               ((ID_EX_Rt == ID_Rs) || (ID_Uses_Rt && (ID_EX_Rt == ID_Rt)));
    // In MD_WAIT the hold lasts until done; elsewhere a start that is not
    // already done opens the wait. A start completing in its own cycle is free.
    if (state == MD_WAIT) md_hold = !md_done;
    else                  md_hold = EX_MD_Start && !md_done;
  end

  // Next-state and Mealy outputs, priority freeze > MD > JB_WAIT > load-use > JB.
  always_comb begin
    ctl        = CTL_RUN;
    state_nxt  = state;
    jb_cnt_nxt = jb_cnt;
    if (freeze) begin
      ctl = CTL_FREEZE;                 // everything, including jb_cnt, held
    end else if (md_hold) begin
      ctl       = CTL_MD;               // jb_cnt parked until the unit is done
      state_nxt = MD_WAIT;
    end else begin
      case (state)
        MD_WAIT: begin
          // done cycle runs with default controls, then resume any JB window
          state_nxt = (jb_cnt != 3'd0) ? JB_WAIT : RUN;
        end
        JB_WAIT: begin
          ctl        = CTL_JB;
          jb_cnt_nxt = jb_cnt - 3'd1;
          if (jb_cnt <= 3'd1) begin
            state_nxt  = RUN;
            jb_cnt_nxt = 3'd0;
          end
        end
        default: begin
          state_nxt = RUN;
          if (load_use) begin
            ctl = CTL_LU;
          end else if (ID_Is_JB && JB_EN) begin
            // this cycle proceeds so the delay slot is fetched
            state_nxt  = JB_WAIT;
            jb_cnt_nxt = JB_LOAD;
          end
        end
      endcase
    end
  end

  // State and JB countdown registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      jb_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      jb_cnt <= jb_cnt_nxt;
    end
  end

  // Front-end stall counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       stall_q <= 32'd0;
    else if (!ctl.pc_w) stall_q <= stall_q + 32'd1;
  end

  assign PC_Write     = ctl.pc_w;
  assign IF_ID_Write  = ctl.if_id_w;
  assign ID_EX_Write  = ctl.id_ex_w;
  assign EX_MEM_Write = ctl.ex_mem_w;
  assign MEM_WB_Write = ctl.mem_wb_w;
  assign IF_ID_Flush  = ctl.if_id_fl;
  assign ID_EX_Flush  = ctl.id_ex_fl;
  assign EX_MEM_Flush = ctl.ex_mem_fl;
  assign Is_JB_stall  = (state == JB_WAIT);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: three instances (JB_STALL_CYCLES = 2, 3, 0) share one
// stimulus stream; a behavioural model per instance predicts every output each
// cycle, and directed sequences pin the model with hand-computed values.
module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic       jb;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       md_start;
    logic       md_done;
    logic       memwait;
  } stim_t;

  // output vector order: PC IF_ID ID_EX EX_MEM MEM_WB | fIF_ID fID_EX fEX_MEM | JBstall
  localparam logic [8:0] O_IDLE = 9'b11111_000_0;
  localparam logic [8:0] O_LU   = 9'b00111_010_0;
  localparam logic [8:0] O_MD   = 9'b00011_001_0;
  localparam logic [8:0] O_MDJB = 9'b00011_001_1;
  localparam logic [8:0] O_JBW  = 9'b01111_100_1;
  localparam logic [8:0] O_FRZJ = 9'b00000_000_1;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  stim_t s = '0;
  wire [8:0]  dv [3];
  wire [31:0] sc [3];

  int nchecks = 0;
  int nerr    = 0;

  // model state per instance: remaining JB cycles, MD wait pending, stall count
  int          mjl [3];
  bit          mmd [3];
  logic [31:0] mcnt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_stall_ctrl #(.JB_STALL_CYCLES(g == 0 ? 2 : (g == 1 ? 3 : 0))) dut (
      .clk(clk), .reset_n(reset_n),
      .ID_Is_JB(s.jb), .ID_Rs(s.rs), .ID_Rt(s.rt), .ID_Uses_Rt(s.uses_rt),
      .ID_EX_MemRead(s.memread), .ID_EX_Rt(s.ex_rt),
      .EX_MD_Start(s.md_start), .md_done(s.md_done),
      .mem_waitrequest(s.memwait),
      .PC_Write(dv[g][8]), .IF_ID_Write(dv[g][7]), .ID_EX_Write(dv[g][6]),
      .EX_MEM_Write(dv[g][5]), .MEM_WB_Write(dv[g][4]),
      .IF_ID_Flush(dv[g][3]), .ID_EX_Flush(dv[g][2]), .EX_MEM_Flush(dv[g][1]),
      .Is_JB_stall(dv[g][0]), .stall_cycles(sc[g])
    );
  end

  function automatic int pstall(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural rules: "md" = waiting on mult/div, "jl" = suppressed fetch
  // cycles still owed for the last jump/branch.
  function automatic void model(input int p, input bit md, input int jl, input stim_t x,
                                output logic [8:0] e, output bit nmd, output int njl);
    bit in_jb, lu, hold;
    in_jb = !md && (jl > 0);
    lu    = x.memread && (x.ex_rt != 0) &&
            (x.ex_rt == x.rs || (x.uses_rt && x.ex_rt == x.rt));
    hold  = md ? !x.md_done : (x.md_start && !x.md_done);
    nmd = md;
    njl = jl;
    e   = O_IDLE;
    if (x.memwait)   e = 9'b00000_000_0;
    else if (hold) begin e = O_MD; nmd = 1'b1; end
    else if (md)     nmd = 1'b0;
    else if (in_jb) begin e = O_JBW; njl = jl - 1; end
    else if (lu)     e = O_LU;
    else if (x.jb)   njl = p;
    e[0] = in_jb;
  endfunction

  // One clock: drive at negedge, compare all instances, commit model after posedge.
  task automatic cycle(input stim_t x, input int li, input logic [8:0] lexp, input string nm);
    logic [8:0] e;
    logic [8:0] ea [3];
    bit nmd;
    int njl;
    bit nmda [3];
    int njla [3];
    @(negedge clk);
    s = x;
    #2;
    for (int i = 0; i < 3; i++) begin
      model(pstall(i), mmd[i], mjl[i], x, e, nmd, njl);
      chk($sformatf("outs[%0d]", i), 32'(dv[i]), 32'(e));
      chk($sformatf("stall_cycles[%0d]", i), sc[i], mcnt[i]);
      if (li == i) chk(nm, 32'(dv[i]), 32'(lexp));
      ea[i] = e; nmda[i] = nmd; njla[i] = njl;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mmd[i] = nmda[i];
      mjl[i] = njla[i];
      if (!ea[i][8]) mcnt[i] = mcnt[i] + 32'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin mjl[i] = 0; mmd[i] = 1'b0; mcnt[i] = 32'd0; end
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_outs[%0d]", tag, i), 32'(dv[i]), 32'(O_IDLE));
      chk($sformatf("%s_cnt[%0d]", tag, i), sc[i], 32'd0);
    end
  endtask

  initial begin
    stim_t idle, x;
    idle = '0;
    model_reset();
    #3;
    reset_checks("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // load-use: one bubble, then a $0 destination never stalls
    x = idle; x.memread = 1'b1; x.ex_rt = 5'd3; x.rs = 5'd3;
    cycle(x, 0, O_LU, "lu_bubble");
    chk("lu_cnt", sc[0], 32'd1);
    x.ex_rt = 5'd0; x.rs = 5'd0;
    cycle(x, 0, O_IDLE, "lu_rt0");
    chk("lu_rt0_cnt", sc[0], 32'd1);

    // branch with 2 suppressed cycles on instance 0
    x = idle; x.jb = 1'b1;
    cycle(x, 0, O_IDLE, "jb_trigger");
    cycle(idle, 0, O_JBW, "jb_wait1");
    cycle(idle, 0, O_JBW, "jb_wait2");
    cycle(idle, 0, O_IDLE, "jb_done");
    chk("jb_cnt", sc[0], 32'd3);
    cycle(idle, 2, O_IDLE, "jb0_idle");
    cycle(idle, -1, O_IDLE, "");

    // mult/div: 4 held cycles, done cycle normal, same-cycle done free
    x = idle; x.md_start = 1'b1;
    cycle(x, 0, O_MD, "md_start");
    for (int k = 0; k < 3; k++) cycle(idle, 0, O_MD, "md_wait");
    x = idle; x.md_done = 1'b1;
    cycle(x, 0, O_IDLE, "md_done");
    chk("md_cnt", sc[0], 32'd7);
    x.md_start = 1'b1;
    cycle(x, 0, O_IDLE, "md_instant");

    // mult/div inside JB_WAIT on instance 1 (3 cycles): window resumes in full
    x = idle; x.jb = 1'b1;
    cycle(x, 1, O_IDLE, "mdjb_trigger");
    x = idle; x.md_start = 1'b1;
    cycle(x, 1, O_MDJB, "mdjb_start");
    cycle(idle, 1, O_MD, "mdjb_wait");
    x = idle; x.md_done = 1'b1;
    cycle(x, 1, O_IDLE, "mdjb_done");
    for (int k = 0; k < 3; k++) cycle(idle, 1, O_JBW, "mdjb_resume");
    cycle(idle, 1, O_IDLE, "mdjb_run");
    chk("mdjb_cnt", sc[1], 32'd13);

    // freeze for 3 cycles in JB_WAIT with 2 cycles owed (instance 0)
    x = idle; x.jb = 1'b1;
    cycle(x, 0, O_IDLE, "frz_trigger");
    x = idle; x.memwait = 1'b1;
    for (int k = 0; k < 3; k++) cycle(x, 0, O_FRZJ, "frz_hold");
    cycle(idle, 0, O_JBW, "frz_jb1");
    cycle(idle, 0, O_JBW, "frz_jb2");
    cycle(idle, 0, O_IDLE, "frz_run");
    chk("frz_cnt", sc[0], 32'd16);

    // counter wrap
    force g_dut[0].dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release g_dut[0].dut.stall_q;
    mcnt[0] = 32'hFFFF_FFFF;
    x = idle; x.memread = 1'b1; x.ex_rt = 5'd7; x.rt = 5'd7; x.uses_rt = 1'b1;
    cycle(x, 0, O_LU, "wrap_lu");
    chk("wrap_cnt", sc[0], 32'd0);

    // randomized traffic with narrow register range to force collisions
    for (int n = 0; n < 400; n++) begin
      x.jb       = ($urandom_range(0, 4) == 0);
      x.rs       = 5'($urandom_range(0, 3));
      x.rt       = 5'($urandom_range(0, 3));
      x.uses_rt  = 1'($urandom);
      x.memread  = ($urandom_range(0, 2) == 0);
      x.ex_rt    = 5'($urandom_range(0, 3));
      x.md_start = ($urandom_range(0, 7) == 0);
      x.md_done  = ($urandom_range(0, 2) == 0);
      x.memwait  = ($urandom_range(0, 9) == 0);
      cycle(x, -1, O_IDLE, "");
    end

    // asynchronous reset while waiting on mult/div
    x = idle; x.md_start = 1'b1;
    cycle(x, -1, O_IDLE, "");
    #2;
    s = idle;
    #1;
    reset_n = 1'b0;
    #1;
    reset_checks("mdreset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(idle, 0, O_IDLE, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Hazard and stall sequencer for the 5-stage MIPS pipeline. It produces every stage-register write-enable and flush, including the IF/ID write-enable and jump/branch stall flag consumed by the PC link chain. It resolves four stall sources: load-use, post-jump/branch fetch suppression, multi-cycle mult/div wait, and data-memory wait. A free-running counter exposes total front-end stall cycles for performance checks.

## Interface
- JB_STALL_CYCLES, 1, fetch-suppression cycles after a jump/branch leaves ID; legal 0..7
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ID_Is_JB  in  1  jump/branch instruction valid in ID
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_Uses_Rt  in  1  ID instruction reads rt
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  5  load destination in EX
- EX_MD_Start  in  1  mult/div issued in EX this cycle
- md_done  in  1  mult/div result ready
- mem_waitrequest  in  1  data memory not ready (MEM stage)
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  stage register write-enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  load bubble into that register
- Is_JB_stall  out  1  high while in JB_WAIT
- stall_cycles  out  32  count of cycles with PC_Write=0

## Operation
- FSM states:
  - RUN: normal issue.
  - JB_WAIT: suppress fetch after a jump/branch.
  - MD_WAIT: hold the front end for mult/div.
- 3-bit jb_cnt holds remaining JB_WAIT cycles.
- Outputs are Mealy: a function of state and current inputs. Default: all *_Write=1, all *_Flush=0.
- Global freeze, highest priority, any state:
  - Condition: mem_waitrequest=1.
  - All five *_Write=0; all flushes 0.
  - State, jb_cnt and pending transitions are held.
  - stall_cycles increments.
- Load-use hazard, evaluated in RUN only:
  - Condition: ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==ID_Rs || (ID_Uses_Rt && ID_EX_Rt==ID_Rt)).
  - Action: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - State stays RUN.
- Jump/branch:
  - Trigger: in RUN, ID_Is_JB=1, no load-use hazard, no freeze.
  - That cycle proceeds normally; the delay slot is fetched.
  - If JB_STALL_CYCLES>0: next state JB_WAIT, jb_cnt=JB_STALL_CYCLES.
- JB_WAIT:
  - PC_Write=0, IF_ID_Flush=1, Is_JB_stall=1.
  - jb_cnt decrements each unfrozen cycle.
  - When jb_cnt==1 and decrementing, next state RUN.
- Mult/div:
  - Trigger: in RUN or JB_WAIT, EX_MD_Start=1 && md_done=0.
  - Same cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1.
  - Next state MD_WAIT.
  - EX_MD_Start with md_done=1 in the same cycle: no stall.
- MD_WAIT:
  - Same holds as the mult/div trigger cycle while md_done=0.
  - jb_cnt is frozen; Is_JB_stall=0.
  - On md_done=1, that cycle uses default outputs. Next state is JB_WAIT if jb_cnt>0, else RUN.
- Priority: freeze > MD > JB_WAIT actions > load-use > JB trigger.
  - A JB_WAIT cycle that also starts MD applies MD outputs.
  - That cycle does not decrement jb_cnt.
- stall_cycles:
  - +1 every cycle PC_Write=0.
  - 32-bit, wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=RUN, jb_cnt=0, stall_cycles=0, Is_JB_stall=0.
  - With idle inputs, all *_Write=1 and all *_Flush=0.
- Reset mid-stall (any state) returns to RUN immediately; no pending JB or MD is remembered.
- Zero-cycle decision latency: hazard outputs are valid in the same cycle the inputs are valid.
- Load-use costs exactly 1 bubble.
- Jump/branch costs JB_STALL_CYCLES fetch-suppressed cycles, plus any freeze cycles.
- MD stall length is the number of cycles from EX_MD_Start until md_done, exclusive of the done cycle.
- JB_STALL_CYCLES=0: the FSM never enters JB_WAIT.

## Test plan
- Load-use: lw $3 in EX (ID_EX_MemRead=1, ID_EX_Rt=3), ID_Rs=3 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles=1. Repeat with ID_EX_Rt=0 -> no stall.
- Branch, JB_STALL_CYCLES=2: ID_Is_JB=1 for one cycle -> that cycle normal; next 2 cycles Is_JB_stall=1, PC_Write=0, IF_ID_Flush=1; then RUN; stall_cycles=2.
- Mult/div: EX_MD_Start=1, md_done after 4 cycles -> 4 cycles with PC/IF_ID/ID_EX writes 0 and EX_MEM_Flush=1; done cycle normal. EX_MD_Start with md_done=1 in the same cycle -> no stall.
- MD inside JB_WAIT, JB_STALL_CYCLES=3: EX_MD_Start in the first JB_WAIT cycle, md_done 2 cycles later -> JB_WAIT resumes with jb_cnt=3, i.e. 3 further Is_JB_stall cycles.
- Freeze: mem_waitrequest=1 for 3 cycles during JB_WAIT with jb_cnt=2 -> all five writes 0 for 3 cycles; jb_cnt still 2 afterwards; stall_cycles +3.
- Reset mid-MD_WAIT: pulse reset_n low asynchronously -> immediately RUN, stall_cycles=0, all writes 1. Separately, preset stall_cycles=0xFFFFFFFF and stall once -> wraps to 0.
